// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [31:0] ERR_RDATA = 32'hDEADBEEF;

endpackage

// File: rtl/mem_arbiter.sv
// Round-robin arbiter granting one of two requesters access to a single memory slave,
// with a per-transaction timeout that completes the owner with an error response.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        m0_valid,
  input  logic [3:0]  m0_wstrb,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,
  output logic        m0_err,
  input  logic        m1_valid,
  input  logic [3:0]  m1_wstrb,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,
  output logic        m1_err,
  output logic        s_valid,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic        s_ready,
  input  logic [31:0] s_rdata
);

  // The abort fires in the BUSY cycle in which the counter would reach TIMEOUT.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic        owner_q, owner_d;
  logic        last_owner_q, last_owner_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        grant;
  logic        done_ok;
  logic        done_to;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      cnt_q        <= 8'd0;
      addr_q       <= 32'd0;
      wdata_q      <= 32'd0;
      wstrb_q      <= 4'd0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    grant        = 1'b0;
    done_ok      = 1'b0;
    done_to      = 1'b0;
    case (state_q)
      IDLE: begin
        if (m0_valid || m1_valid) begin
          grant   = (m0_valid && m1_valid) ? ~last_owner_q : m1_valid;
          owner_d = grant;
          addr_d  = grant ? m1_addr  : m0_addr;
          wdata_d = grant ? m1_wdata : m0_wdata;
          wstrb_d = grant ? m1_wstrb : m0_wstrb;
          cnt_d   = 8'd0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        // A slave completion takes priority over a timeout landing in the same cycle.
        if (s_ready) begin
          done_ok      = 1'b1;
          last_owner_d = owner_q;
          state_d      = DONE;
        end else if (cnt_q == TMO_LAST) begin
          done_to      = 1'b1;
          last_owner_d = owner_q;
          state_d      = DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  logic        resp;
  logic [31:0] resp_rdata;

  assign resp       = done_ok | done_to;
  assign resp_rdata = done_ok ? s_rdata : ERR_RDATA;

  assign s_valid  = (state_q == BUSY);
  assign s_addr   = addr_q;
  assign s_wdata  = wdata_q;
  assign s_wstrb  = wstrb_q;

  assign m0_ready = resp & ~owner_q;
  assign m0_err   = done_to & ~owner_q;
  assign m0_rdata = m0_ready ? resp_rdata : 32'd0;
  assign m1_ready = resp & owner_q;
  assign m1_err   = done_to & owner_q;
  assign m1_rdata = m1_ready ? resp_rdata : 32'd0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench: directed scenarios then random transactions against a
// transaction-level model of grant order, response timing and memory contents.
module tb_mem_arbiter;
  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        m0_valid = 1'b0, m1_valid = 1'b0;
  logic [3:0]  m0_wstrb = '0, m1_wstrb = '0;
  logic [31:0] m0_addr = '0, m1_addr = '0, m0_wdata = '0, m1_wdata = '0;
  logic        m0_ready, m1_ready, m0_err, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_valid;
  logic [31:0] s_addr, s_wdata;
  logic [3:0]  s_wstrb;
  logic        s_ready = 1'b0;
  logic [31:0] s_rdata = '0;

  int nvec = 0;
  int nerr = 0;
  int ntxn = 0;
  logic [31:0] model_mem [64];
  logic [31:0] stub_mem  [64];
  bit last_m = 1'b1;

  always #5 clk = ~clk;

  mem_arbiter #(.TIMEOUT(TMO)) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_valid(m0_valid), .m0_wstrb(m0_wstrb), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ready(m0_ready), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_valid(m1_valid), .m1_wstrb(m1_wstrb), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ready(m1_ready), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_ready(s_ready), .s_rdata(s_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_resp(input string tag, input logic [3:0] flags, input logic [31:0] rd0,
                          input logic [31:0] rd1);
    chk({tag, "_flags"}, 32'({m0_ready, m0_err, m1_ready, m1_err}), 32'(flags));
    chk({tag, "_rdata0"}, m0_rdata, rd0);
    chk({tag, "_rdata1"}, m1_rdata, rd1);
  endtask

  // Called on a falling edge with the arbiter idle; returns on a falling edge, idle again.
  task automatic txn(input bit v0, input bit v1, input bit wr0, input bit wr1,
                     input logic [31:0] a0, input logic [31:0] a1,
                     input logic [31:0] d0, input logic [31:0] d1, input int lat);
    bit w, ewr, to;
    logic [31:0] ea, ed, exp_rd;
    logic [3:0]  flags;
    w   = (v0 && v1) ? !last_m : v1;
    ea  = w ? a1 : a0;
    ed  = w ? d1 : d0;
    ewr = w ? wr1 : wr0;
    to  = 1'b0;
    exp_rd = '0;
    m0_valid = v0; m0_addr = a0; m0_wdata = d0; m0_wstrb = wr0 ? 4'hF : 4'h0;
    m1_valid = v1; m1_addr = a1; m1_wdata = d1; m1_wstrb = wr1 ? 4'hF : 4'h0;
    s_ready = 1'b0;
    #1;
    chk("idle_svalid", 32'(s_valid), 32'd0);
    @(negedge clk);
    // Owner drops its request and both masters scramble their fields mid-transaction.
    m0_valid = 1'b0; m1_valid = 1'b0;
    m0_addr = $urandom; m1_addr = $urandom; m0_wdata = $urandom; m1_wdata = $urandom;
    for (int k = 1; k <= TMO; k++) begin
      s_ready = (k == lat);
      if (s_ready) s_rdata = ewr ? $urandom : stub_mem[s_addr[7:2]];
      else s_rdata = $urandom;
      #1;
      chk("busy_svalid", 32'(s_valid), 32'd1);
      chk("busy_saddr", s_addr, ea);
      chk("busy_swdata", s_wdata, ed);
      chk("busy_swstrb", 32'(s_wstrb), ewr ? 32'hF : 32'h0);
      if (k == lat) begin
        exp_rd = ewr ? s_rdata : model_mem[ea[7:2]];
        flags  = w ? 4'b0010 : 4'b1000;
        if (ewr) begin
          model_mem[ea[7:2]]    = ed;
          stub_mem[s_addr[7:2]] = s_wdata;
        end
      end else if (k == TMO) begin
        exp_rd = 32'hDEADBEEF;
        flags  = w ? 4'b0011 : 4'b1100;
        to     = 1'b1;
      end else begin
        flags = 4'b0000;
      end
      chk_resp("busy", flags, (flags[3]) ? exp_rd : 32'd0, (flags[1]) ? exp_rd : 32'd0);
      @(negedge clk);
      if (k == lat || k == TMO) break;
    end
    last_m = w;
    // A stray slave completion during DONE must be ignored.
    s_ready = 1'($urandom_range(0, 1));
    s_rdata = $urandom;
    #1;
    chk("done_svalid", 32'(s_valid), 32'd0);
    chk_resp("done", 4'b0000, 32'd0, 32'd0);
    @(negedge clk);
    s_ready = 1'b0;
    ntxn++;
    $display("txn %0d: v0=%0d v1=%0d owner=m%0d %s addr=%h lat=%0d %s rdata=%h",
             ntxn, v0, v1, w, ewr ? "wr" : "rd", ea, lat, to ? "timeout" : "ok", exp_rd);
  endtask

  task automatic rand_txn();
    bit v0, v1;
    v0 = 1'($urandom_range(0, 1));
    v1 = v0 ? 1'($urandom_range(0, 1)) : 1'b1;
    txn(v0, v1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
        {24'd0, 6'($urandom), 2'b00}, {24'd0, 6'($urandom), 2'b00},
        $urandom, $urandom, $urandom_range(1, TMO + 3));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 64; i++) begin
      model_mem[i] = 32'(i);
      stub_mem[i]  = 32'(i);
    end
    #2;
    chk("rst_svalid", 32'(s_valid), 32'd0);
    chk("rst_saddr", s_addr, 32'd0);
    chk("rst_swdata", s_wdata, 32'd0);
    chk("rst_swstrb", 32'(s_wstrb), 32'd0);
    chk_resp("rst", 4'b0000, 32'd0, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // Simultaneous requests after reset: m0 first, then m1.
    txn(1, 1, 0, 0, 32'h20, 32'h24, 32'h0, 32'h0, 2);
    txn(1, 1, 0, 0, 32'h28, 32'h2C, 32'h0, 32'h0, 1);
    // Lone m0 read of 0x10.
    txn(1, 0, 0, 0, 32'h10, 32'h0, 32'h0, 32'h0, 1);
    // m1 writes, m0 reads back.
    txn(0, 1, 0, 1, 32'h0, 32'h80, 32'h0, 32'hCAFEF00D, 1);
    txn(1, 0, 0, 0, 32'h80, 32'h0, 32'h0, 32'h0, 3);
    // Slave silent: timeout with error.
    txn(1, 0, 0, 0, 32'h40, 32'h0, 32'h0, 32'h0, TMO + 5);
    // s_ready lands in the timeout cycle: normal completion.
    txn(0, 1, 0, 0, 32'h0, 32'h80, 32'h0, 32'h0, TMO);

    // Reset pulsed mid-BUSY.
    m1_valid = 1'b1; m1_addr = 32'h44; m1_wstrb = 4'h0;
    @(negedge clk);
    m1_valid = 1'b0;
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("midrst_svalid", 32'(s_valid), 32'd0);
    chk("midrst_saddr", s_addr, 32'd0);
    chk_resp("midrst", 4'b0000, 32'd0, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    last_m = 1'b1;
    txn(0, 1, 0, 0, 32'h0, 32'h84, 32'h0, 32'h0, 3);
    txn(1, 1, 0, 0, 32'h8, 32'hC, 32'h0, 32'h0, 2);

    for (int i = 0; i < 60; i++) rand_txn();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 64: cycles in BUSY without s_ready before the transaction is aborted (legal range 2..255).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 m0_valid / m0_wstrb[3:0] / m0_addr[31:0] / m0_wdata[31:0]  input  requester 0 (instruction fetch) request; wstrb 4'b0000 = read, 4'b1111 = write.
REQ-005 m0_ready  output  1  one-cycle completion pulse to requester 0.
REQ-006 m0_rdata  output  32  read data to requester 0, valid only while m0_ready=1.
REQ-007 m0_err  output  1  high with m0_ready when the transaction timed out.
REQ-008 m1_valid / m1_wstrb[3:0] / m1_addr[31:0] / m1_wdata[31:0]  input  requester 1 (data port) request; same encoding.
REQ-009 m1_ready, m1_rdata[31:0], m1_err  output  same meaning as the m0 outputs, for requester 1.
REQ-010 s_valid  output  1  request to the shared memory slave (BRAM controller).
REQ-011 s_addr[31:0] / s_wdata[31:0] / s_wstrb[3:0]  output  latched request fields to the slave.
REQ-012 s_ready  input  1  slave completion pulse.
REQ-013 s_rdata  input  32  slave read data, valid while s_ready=1.

Function
REQ-014 The FSM SHALL have states IDLE, BUSY and DONE; owner is a 1-bit register and last_owner is a 1-bit register.
REQ-015 In IDLE with exactly one mN_valid=1, the arbiter SHALL grant N: latch addr/wdata/wstrb, set owner=N and enter BUSY on the next edge.
REQ-016 In IDLE with both valid, the arbiter SHALL grant the requester != last_owner (round-robin).
REQ-017 s_valid SHALL equal 1 exactly while in BUSY; s_addr/s_wdata/s_wstrb SHALL hold the latched values and stay stable throughout BUSY.
REQ-018 In BUSY with s_ready=1: m<owner>_ready=1 and m<owner>_rdata=s_rdata combinationally in that cycle; err=0; last_owner<=owner; the next state SHALL be DONE.
REQ-019 DONE SHALL last one cycle with s_valid=0 and then return to IDLE, so the slave sees valid low before any new grant.
REQ-020 Grant-to-s_valid latency SHALL be 1 cycle; minimum spacing between back-to-back grants SHALL be 2 cycles after a completion.
REQ-021 An 8-bit counter SHALL clear on BUSY entry and increment each BUSY cycle without s_ready; on reaching TIMEOUT it SHALL pulse m<owner>_ready=1 and m<owner>_err=1 with m<owner>_rdata=32'hDEADBEEF, update last_owner, and go to DONE.
REQ-022 If s_ready and the timeout occur in the same cycle, s_ready SHALL win (normal completion, err=0).
REQ-023 The non-owner's ready/err SHALL stay 0; its rdata SHALL be 0.
REQ-024 Deassertion of mN_valid by the owner while in BUSY SHALL be ignored; the latched transaction completes.
REQ-025 s_ready received outside BUSY SHALL be ignored.

Reset
REQ-026 reset_n=0 SHALL immediately force state=IDLE, owner=0, last_owner=1 (m0 wins the first tie), counter=0, s_valid=0, all mN_ready/err=0, latched fields=0.
REQ-027 Reset asserted mid-BUSY SHALL abort without any ready pulse; after release, arbitration restarts from IDLE.

Structure
REQ-028 Package mem_arb_pkg SHALL hold state_t (IDLE, BUSY, DONE) and the constant ERR_RDATA=32'hDEADBEEF.
REQ-029 No sub-module is required; grant, latch, timer and FSM SHALL live in mem_arbiter, which instantiates no memory.

Verification
REQ-030 Only m0 reads 0x10 with the BRAM controller attached -> s_valid 1 cycle after grant; m0_ready with m0_rdata=0x4; m1 outputs stay 0.
REQ-031 m0 and m1 valid in the same cycle after reset -> m0 served first, then m1; a second simultaneous request -> m1 is not starved (order alternates).
REQ-032 m1 writes 0xCAFEF00D to 0x80 (wstrb=1111), then m0 reads 0x80 -> m0_rdata=0xCAFEF00D.
REQ-033 Slave stub never asserts s_ready, TIMEOUT=8 -> m0_ready=1 and m0_err=1 with rdata=0xDEADBEEF after 8 BUSY cycles; s_valid drops in DONE.
REQ-034 s_ready coincides with the timeout cycle -> err=0 and rdata=s_rdata.
REQ-035 reset_n pulsed low mid-BUSY -> s_valid=0 and ready=0 the same cycle; after release a new m1 request completes normally.
